// File: rtl/morse_rx.sv
// Morse line receiver: measures mark and space runs in dot units of K clocks and rebuilds the left-aligned element pattern.
// Optional MORSE_RX_GLITCH_EN: marks shorter than K/2 clocks are ignored and gap timing carries on across them.
module morse_rx #(
    parameter int K = 50,
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         word,
    output logic         err
);
    localparam int CW = $clog2(8*K + 1);
    localparam int PW = $clog2(W + 1);
    localparam logic [CW-1:0] C_2K = CW'(2*K);
    localparam logic [CW-1:0] C_3K = CW'(3*K);
    localparam logic [CW-1:0] C_5K = CW'(5*K);
    localparam logic [CW-1:0] C_7K = CW'(7*K);
    localparam logic [CW-1:0] C_8K = CW'(8*K);
`ifdef MORSE_RX_GLITCH_EN
    localparam logic [CW-1:0] C_KH = CW'(K/2);
`endif

    typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [W-1:0]  r_buf, w_buf_nx;
    logic [W-1:0]  r_y, w_y_nx;
    logic [PW-1:0] r_ptr, w_ptr_nx;
    logic          r_drop, w_drop_nx;
    logic          r_valid, w_valid_nx;
    logic          r_word, w_word_nx;
    logic          r_err, w_err_nx;
`ifdef MORSE_RX_GLITCH_EN
    logic [CW-1:0] r_save, w_save_nx;
    logic          r_from_gap, w_from_gap_nx;
`endif

    logic          w_gap_eval;
    logic [CW-1:0] w_gap_old, w_gap_new;
    logic          w_dash, w_mark_err;
    logic [PW-1:0] w_width;
    logic [W-1:0]  w_pat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_y     <= '0;
            r_ptr   <= PW'(W);
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
            r_word  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MORSE_RX_GLITCH_EN
            r_save     <= '0;
            r_from_gap <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_buf   <= w_buf_nx;
            r_y     <= w_y_nx;
            r_ptr   <= w_ptr_nx;
            r_drop  <= w_drop_nx;
            r_valid <= w_valid_nx;
            r_word  <= w_word_nx;
            r_err   <= w_err_nx;
`ifdef MORSE_RX_GLITCH_EN
            r_save     <= w_save_nx;
            r_from_gap <= w_from_gap_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_buf_nx   = r_buf;
        w_y_nx     = r_y;
        w_ptr_nx   = r_ptr;
        w_drop_nx  = r_drop;
        w_valid_nx = 1'b0;
        w_word_nx  = 1'b0;
        w_err_nx   = 1'b0;
`ifdef MORSE_RX_GLITCH_EN
        w_save_nx     = r_save;
        w_from_gap_nx = r_from_gap;
`endif
        w_gap_eval = 1'b0;
        w_gap_old  = r_cnt;
        w_gap_new  = r_cnt + CW'(1);
        w_dash     = (r_cnt >= C_2K);
        w_width    = w_dash ? PW'(4) : PW'(2);
        w_pat      = (w_dash ? W'(4'b1110) : W'(2'b10)) << (r_ptr - w_width);
        w_mark_err = 1'b0;

        case (r_state)
            IDLE: begin
                if (in) begin
                    w_state_nx = MARK;
                    w_cnt_nx   = CW'(1);
`ifdef MORSE_RX_GLITCH_EN
                    w_from_gap_nx = 1'b0;
`endif
                end
            end
            MARK: begin
                if (in) begin
                    if (r_cnt != C_8K)
                        w_cnt_nx = r_cnt + CW'(1);
                end else begin
`ifdef MORSE_RX_GLITCH_EN
                    // Glitch: fold its length back into the interrupted gap.
                    if (r_cnt < C_KH) begin
                        if (r_from_gap) begin
                            w_gap_eval = 1'b1;
                            w_gap_old  = r_save;
                            w_gap_new  = r_save + r_cnt + CW'(1);
                        end else begin
                            w_state_nx = IDLE;
                            w_cnt_nx   = '0;
                        end
                    end else
`endif
                    begin
                        w_state_nx = GAP;
                        w_cnt_nx   = CW'(1);
                        if (r_cnt >= C_5K)
                            w_mark_err = 1'b1;
                        else if (!r_drop) begin
                            if (w_width <= r_ptr) begin
                                w_buf_nx = r_buf | w_pat;
                                w_ptr_nx = r_ptr - w_width;
                            end else
                                w_mark_err = 1'b1;
                        end
                        if (w_mark_err) begin
                            w_err_nx  = 1'b1;
                            w_buf_nx  = '0;
                            w_ptr_nx  = PW'(W);
                            w_drop_nx = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (in) begin
                    w_state_nx = MARK;
                    w_cnt_nx   = CW'(1);
`ifdef MORSE_RX_GLITCH_EN
                    w_save_nx     = r_cnt;
                    w_from_gap_nx = 1'b1;
`endif
                end else
                    w_gap_eval = 1'b1;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        // Thresholds fire on crossing so a resumed gap cannot skip them.
        if (w_gap_eval) begin
            w_state_nx = GAP;
            w_cnt_nx   = w_gap_new;
            if (w_gap_old < C_3K && w_gap_new >= C_3K) begin
                if (r_ptr != PW'(W) && !r_drop) begin
                    w_valid_nx = 1'b1;
                    w_y_nx     = r_buf;
                end
                w_buf_nx  = '0;
                w_ptr_nx  = PW'(W);
                w_drop_nx = 1'b0;
            end
            if (w_gap_new >= C_7K) begin
                w_word_nx  = 1'b1;
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign word  = r_word;
    assign err   = r_err;
endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx with K=4: letters, word gap, overflow, long mark, classification boundaries, reset.
module tb_morse_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        line_in = 1'b0;
    logic [23:0] y;
    logic        valid, word, err;

    int n_checks = 0;
    int n_errors = 0;
    int acc_valid, acc_word, acc_err;

    morse_rx #(.K(4), .W(24)) dut (
        .clk(clk), .rst(rst), .in(line_in),
        .y(y), .valid(valid), .word(word), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        acc_valid = 0;
        acc_word  = 0;
        acc_err   = 0;
    endtask

    // One sampling edge per clock; outputs are read 1 time unit after the edge.
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            line_in = v;
            @(posedge clk);
            #1;
            acc_valid += int'(valid);
            acc_word  += int'(word);
            acc_err   += int'(err);
        end
    endtask

    task automatic dashes(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 12);
            drive(1'b0, 4);
        end
    endtask

    // Single mark of length m, then a 12-clock gap ending in a valid.
    task automatic letter(input string tag, input int m, input logic [23:0] exp_y);
        clr();
        drive(1'b1, m);
        drive(1'b0, 11);
        chk({tag, "_early"}, acc_valid, 0);
        drive(1'b0, 1);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_y"}, y, exp_y);
        drive(1'b0, 16);
    endtask

    initial begin
        rst = 1'b0;
        line_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_y", y, 0);
        chk("rst_flags", {valid, word, err}, 0);
        rst = 1'b1;

        // A: dot, dash, then exact 3K and 7K gap timing
        clr();
        drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 12); drive(1'b0, 11);
        chk("a_early", acc_valid, 0);
        drive(1'b0, 1);
        chk("a_valid", valid, 1);
        chk("a_y", y, 24'hB80000);
        drive(1'b0, 1);
        chk("a_one_cycle", valid, 0);
        chk("a_hold_y", y, 24'hB80000);
        drive(1'b0, 14);
        chk("a_word_early", acc_word, 0);
        drive(1'b0, 1);
        chk("a_word", word, 1);
        chk("a_err", acc_err, 0);

        // E then word gap, then idle stays quiet
        clr();
        drive(1'b1, 4); drive(1'b0, 12);
        chk("e_valid", valid, 1);
        chk("e_y", y, 24'h800000);
        drive(1'b0, 15);
        chk("e_word_early", acc_word, 0);
        drive(1'b0, 1);
        chk("e_word", word, 1);
        clr();
        drive(1'b0, 40);
        chk("idle_quiet", acc_valid + acc_word + acc_err, 0);

        // Digit 0 and six dashes
        clr();
        dashes(4); drive(1'b1, 12); drive(1'b0, 12);
        chk("zero_valid", valid, 1);
        chk("zero_y", y, 24'hEEEEE0);
        drive(1'b0, 16);
        clr();
        dashes(5); drive(1'b1, 12); drive(1'b0, 12);
        chk("six_y", y, 24'hEEEEEE);
        chk("six_cnt", {acc_valid[7:0], acc_err[7:0]}, 16'h0100);
        drive(1'b0, 16);

        // Overflow: dot after six dashes
        clr();
        dashes(6); drive(1'b1, 4); drive(1'b0, 1);
        chk("ovf_err", err, 1);
        drive(1'b0, 11);
        chk("ovf_no_valid", acc_valid, 0);
        chk("ovf_err_cnt", acc_err, 1);
        chk("ovf_y_hold", y, 24'hEEEEEE);
        letter("ovf_e", 4, 24'h800000);

        // Long mark
        clr();
        drive(1'b1, 20); drive(1'b0, 1);
        chk("long_err", err, 1);
        drive(1'b0, 11);
        chk("long_no_valid", acc_valid, 0);
        drive(1'b0, 16);

        // Classification boundaries
        letter("m7_dot", 7, 24'h800000);
        letter("m8_dash", 8, 24'hE00000);
        letter("m19_dash", 19, 24'hE00000);

        // Gap of 11 continues the letter: I
        clr();
        drive(1'b1, 4); drive(1'b0, 11); drive(1'b1, 4); drive(1'b0, 12);
        chk("i_y", y, 24'hA00000);
        chk("i_cnt", acc_valid, 1);
        drive(1'b0, 16);

        // Reset during the second mark of A
        clr();
        drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 6);
        rst = 1'b0;
        drive(1'b1, 1);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_flags", {valid, word, err}, 0);
        rst = 1'b1;
        drive(1'b0, 3);
        letter("post_rst_e", 4, 24'h800000);

`ifdef MORSE_RX_GLITCH_EN
        clr();
        drive(1'b1, 4); drive(1'b0, 5); drive(1'b1, 1); drive(1'b0, 5);
        chk("glitch_early", acc_valid, 0);
        drive(1'b0, 1);
        chk("glitch_valid", valid, 1);
        chk("glitch_y", y, 24'h800000);
        chk("glitch_err", acc_err, 0);
        drive(1'b0, 16);
`else
        letter("m1_dot", 1, 24'h800000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
